// File: rtl/prio_scan_encoder.sv
// -----------------------------------------------------------------------------
// prio_scan_encoder
//
// Registered, parametrised successor to the combinational 8:3 priority encoder.
// A non-zero request vector is captured while the block is idle, and then
// drained one encoded index per accepted beat, highest priority first. An
// all-zero vector is accepted but produces only a one-cycle zero_err pulse.
//
// Parameters:
//   N  width of the request vector (legal range 2..64)
//   W  width of the encoded index, derived as $clog2(N); not overridable
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   req        request vector (bit N-1 highest priority by default)
//   req_valid  req is valid this cycle
//   req_ready  block can capture a new vector (high only while idle)
//   idx        encoded index of the current highest-priority pending bit
//   idx_valid  idx is valid
//   idx_ready  downstream accepts idx
//   idx_last   idx is the final pending bit of the captured vector
//   zero_err   one-cycle pulse: a captured vector had no bits set
//
// Build option:
//   PSE_LSB_FIRST_EN  when defined, bit 0 is highest priority and idx is the
//                     lowest set bit of pending. Handshake and FSM unchanged.
//
// Every output is a flop or a decode of the state flop, so there is no
// combinational path from req or idx_ready to any output.
// -----------------------------------------------------------------------------
module prio_scan_encoder #(
  parameter  int N = 8,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         req_valid,
  output logic         req_ready,
  output logic [W-1:0] idx,
  output logic         idx_valid,
  input  logic         idx_ready,
  output logic         idx_last,
  output logic         zero_err
);

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_e;

  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  state_e         state_q, state_d;
  logic [N-1:0]   pending_q, pending_d;
  logic [W-1:0]   idx_q;
  logic           idx_last_q;
  logic           zero_err_q, zero_err_d;

  // Priority search over an arbitrary-width vector. The loop runs in the
  // direction opposite to priority so the last hit (the winner) overwrites
  // earlier ones. An empty vector yields 0, which keeps idx at 0 while idle.
  function automatic logic [W-1:0] find_top(input logic [N-1:0] p);
    logic [W-1:0] r;
    r = '0;
`ifdef PSE_LSB_FIRST_EN
    for (int i = N - 1; i >= 0; i--) begin
      if (p[i]) r = W'(i);
    end
`else
    for (int i = 0; i < N; i++) begin
      if (p[i]) r = W'(i);
    end
`endif
    return r;
  endfunction

  // Exactly one bit set: non-zero, and clearing the lowest set bit empties it.
  function automatic logic is_single(input logic [N-1:0] p);
    return (p != '0) && ((p & (p - ONE)) == '0);
  endfunction

  // Next-state logic. idx_q always names the winning bit of pending_q while
  // draining, so clearing that bit on a handshake advances to the next one.
  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q;
    zero_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (req != '0) begin
            pending_d = req;
            state_d   = DRAIN;
          end else begin
            zero_err_d = 1'b1;
          end
        end
      end
      DRAIN: begin
        // New requests are ignored here; req_ready is low.
        if (idx_ready) begin
          pending_d = pending_q & ~(ONE << idx_q);
          if (idx_last_q) state_d = IDLE;
        end
      end
      default: begin
        state_d   = IDLE;
        pending_d = '0;
      end
    endcase
  end

  // idx and idx_last are precomputed from the next pending value so the
  // outputs come straight from flops and the search stays off the output path.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      pending_q  <= '0;
      idx_q      <= '0;
      idx_last_q <= 1'b0;
      zero_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      idx_q      <= find_top(pending_d);
      idx_last_q <= is_single(pending_d);
      zero_err_q <= zero_err_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign idx_valid = (state_q == DRAIN);
  assign idx       = idx_q;
  assign idx_last  = idx_last_q;
  assign zero_err  = zero_err_q;

endmodule

// File: tb/tb_prio_scan_encoder.sv
module tb_prio_scan_encoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] req = '0;
  logic       req_valid = 1'b0;
  logic       idx_ready = 1'b0;
  wire        req_ready, idx_valid, idx_last, zero_err;
  wire  [2:0] idx;

  logic [4:0] req5 = '0;
  logic       req_valid5 = 1'b0;
  logic       idx_ready5 = 1'b0;
  wire        req_ready5, idx_valid5, idx_last5, zero_err5;
  wire  [2:0] idx5;

  int n_cmp = 0;
  int n_err = 0;
  int exp_q[$];

  prio_scan_encoder #(.N(8)) dut (
    .clk(clk), .rst(rst), .req(req), .req_valid(req_valid), .req_ready(req_ready),
    .idx(idx), .idx_valid(idx_valid), .idx_ready(idx_ready), .idx_last(idx_last),
    .zero_err(zero_err)
  );

  prio_scan_encoder #(.N(5)) dut5 (
    .clk(clk), .rst(rst), .req(req5), .req_valid(req_valid5), .req_ready(req_ready5),
    .idx(idx5), .idx_valid(idx_valid5), .idx_ready(idx_ready5), .idx_last(idx_last5),
    .zero_err(zero_err5)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: the order in which set bits are served is simply the
  // list of set bit positions sorted by priority.
  task automatic load_model(input logic [7:0] r);
    exp_q.delete();
`ifdef PSE_LSB_FIRST_EN
    for (int i = 0; i < 8; i++) if (r[i]) exp_q.push_back(i);
`else
    for (int i = 7; i >= 0; i--) if (r[i]) exp_q.push_back(i);
`endif
  endtask

  typedef struct {
    logic [7:0]      req;
    int              n;
    logic [7:0][2:0] seq;   // seq[k] = expected idx of beat k
  } vec_t;

  vec_t tbl[5];

  initial begin
`ifdef PSE_LSB_FIRST_EN
    tbl[0] = '{8'hA4, 3, {3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd7, 3'd5, 3'd2}};
    tbl[1] = '{8'hFF, 8, {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0}};
    tbl[2] = '{8'h01, 1, {3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0}};
    tbl[3] = '{8'h80, 1, {3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd7}};
    tbl[4] = '{8'h81, 2, {3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd7, 3'd0}};
`else
    tbl[0] = '{8'hA4, 3, {3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd2, 3'd5, 3'd7}};
    tbl[1] = '{8'hFF, 8, {3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7}};
    tbl[2] = '{8'h01, 1, {3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0}};
    tbl[3] = '{8'h80, 1, {3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd7}};
    tbl[4] = '{8'h81, 2, {3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd7}};
`endif

    // ---------------- reset ----------------
    step();
    step();
    chk("rst_idx_valid", idx_valid, 0);
    chk("rst_idx", idx, 0);
    chk("rst_idx_last", idx_last, 0);
    chk("rst_zero_err", zero_err, 0);
    rst = 1'b0;
    step();
    chk("rst_req_ready", req_ready, 1);
    chk("rst_idx_valid_after", idx_valid, 0);

    // ---------------- table vectors, idx_ready held high ----------------
    idx_ready = 1'b1;
    for (int t = 0; t < 5; t++) begin
      req       = tbl[t].req;
      req_valid = 1'b1;
      chk("tbl_req_ready_idle", req_ready, 1);
      step();
      req_valid = 1'b0;
      req       = 8'($urandom);
      for (int k = 0; k < tbl[t].n; k++) begin
        chk("tbl_idx_valid", idx_valid, 1);
        chk("tbl_idx", idx, tbl[t].seq[k]);
        chk("tbl_idx_last", idx_last, (k == tbl[t].n - 1) ? 1 : 0);
        chk("tbl_req_ready_busy", req_ready, 0);
        step();
      end
      chk("tbl_idx_valid_end", idx_valid, 0);
      chk("tbl_req_ready_end", req_ready, 1);
    end

    // ---------------- backpressure: 0100_0001, 3 stalled cycles ----------------
    load_model(8'h41);
    req = 8'h41; req_valid = 1'b1;
    step();
    req_valid = 1'b0; idx_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk("bp_hold_valid", idx_valid, 1);
      chk("bp_hold_idx", idx, exp_q[0]);
      chk("bp_hold_last", idx_last, 0);
      step();
    end
    idx_ready = 1'b1;
    chk("bp_acc0_idx", idx, exp_q[0]);
    chk("bp_acc0_last", idx_last, 0);
    step();
    void'(exp_q.pop_front());
    chk("bp_acc1_valid", idx_valid, 1);
    chk("bp_acc1_idx", idx, exp_q[0]);
    chk("bp_acc1_last", idx_last, 1);
    step();
    chk("bp_end_valid", idx_valid, 0);
    chk("bp_end_ready", req_ready, 1);

    // ---------------- zero vector ----------------
    req = 8'h00; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    chk("zero_err_pulse", zero_err, 1);
    chk("zero_idx_valid", idx_valid, 0);
    chk("zero_req_ready", req_ready, 1);
    step();
    chk("zero_err_clear", zero_err, 0);
    chk("zero_idx_valid2", idx_valid, 0);
    chk("zero_req_ready2", req_ready, 1);

    // ---------------- reset mid-drain: 1110_0000 ----------------
    load_model(8'hE0);
    req = 8'hE0; req_valid = 1'b1; idx_ready = 1'b1;
    step();
    req_valid = 1'b0;
    chk("mrst_first_idx", idx, exp_q[0]);
    chk("mrst_first_valid", idx_valid, 1);
    step();                    // first beat accepted
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mrst_idx_valid", idx_valid, 0);
    chk("mrst_req_ready", req_ready, 1);
    chk("mrst_idx_last", idx_last, 0);
    for (int c = 0; c < 4; c++) begin
      step();
      chk("mrst_no_beats", idx_valid, 0);
    end

    // ---------------- N=5 instance: 10010 ----------------
    req5 = 5'b10010; req_valid5 = 1'b1; idx_ready5 = 1'b1;
    step();
    req_valid5 = 1'b0;
    chk("n5_valid0", idx_valid5, 1);
`ifdef PSE_LSB_FIRST_EN
    chk("n5_idx0", idx5, 3'd1);
`else
    chk("n5_idx0", idx5, 3'b100);
`endif
    chk("n5_last0", idx_last5, 0);
    step();
`ifdef PSE_LSB_FIRST_EN
    chk("n5_idx1", idx5, 3'd4);
`else
    chk("n5_idx1", idx5, 3'd1);
`endif
    chk("n5_last1", idx_last5, 1);
    chk("n5_zero_err", zero_err5, 0);
    step();
    chk("n5_end_valid", idx_valid5, 0);
    chk("n5_end_ready", req_ready5, 1);

    // ---------------- randomized vectors against the model ----------------
    for (int v = 0; v < 60; v++) begin
      logic [7:0] r;
      int         sel;
      int         cyc;
      logic       rdy;
      sel = $urandom_range(0, 5);
      if (sel == 0)      r = 8'h00;
      else if (sel == 1) r = 8'h01 << $urandom_range(0, 7);
      else               r = 8'($urandom);
      load_model(r);
      chk("rnd_req_ready_idle", req_ready, 1);
      req = r; req_valid = 1'b1;
      step();
      if (r == 8'h00) begin
        req_valid = 1'b0;
        chk("rnd_zero_err", zero_err, 1);
        chk("rnd_zero_valid", idx_valid, 0);
        step();
        chk("rnd_zero_err_clear", zero_err, 0);
      end else begin
        cyc = 0;
        while (exp_q.size() > 0 && cyc < 200) begin
          chk("rnd_valid", idx_valid, 1);
          chk("rnd_idx", idx, exp_q[0]);
          chk("rnd_last", idx_last, (exp_q.size() == 1) ? 1 : 0);
          chk("rnd_req_ready_busy", req_ready, 0);
          chk("rnd_zero_err_busy", zero_err, 0);
          rdy       = ($urandom_range(0, 2) != 0);
          idx_ready = rdy;
          req_valid = 1'($urandom_range(0, 1));  // must be ignored while draining
          req       = 8'($urandom);
          step();
          if (rdy) void'(exp_q.pop_front());
          cyc++;
        end
        if (exp_q.size() > 0) chk("rnd_timeout", 1, 0);
        req_valid = 1'b0;
        chk("rnd_end_valid", idx_valid, 0);
        chk("rnd_end_ready", req_ready, 1);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/prio_scan_encoder.md
Name: prio_scan_encoder

Overview:
- Parametrised, registered successor to the combinational 8:3 priority encoder.
- Captures an N-bit request vector and drains it over successive cycles, emitting one encoded index per beat in priority order.
- Uses valid/ready on both sides.
- Sits between interrupt/request collectors and downstream servicing logic that consumes one index at a time.

Parameters:
- N, 8, width of request vector; legal range 2..64.
- W, $clog2(N), width of encoded index output. Derived; must not be overridden.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- req  input  N  request vector; bit N-1 is highest priority
- req_valid  input  1  req is valid this cycle
- req_ready  output  1  block can capture a new vector
- idx  output  W  encoded index of the current highest-priority pending bit
- idx_valid  output  1  idx is valid
- idx_ready  input  1  downstream accepts idx
- idx_last  output  1  idx is the final pending bit of the captured vector
- zero_err  output  1  one-cycle pulse: a captured vector had no bits set

Behaviour:
- Reset (rst=1 at clock edge):
  - state <= IDLE, pending <= 0.
  - idx_valid=0, idx=0, idx_last=0, zero_err=0.
  - req_ready reads 1 from the cycle after reset deasserts.
- Reset mid-drain discards all pending bits. No further idx beats are produced for that vector.
- States: IDLE, DRAIN.
- IDLE:
  - req_ready=1, idx_valid=0.
  - On req_valid && req_ready:
    - If req != 0: pending <= req, go to DRAIN.
    - If req == 0: stay in IDLE; zero_err=1 for exactly the next cycle; no idx beat.
- DRAIN:
  - req_ready=0; req/req_valid ignored.
  - idx_valid=1.
  - idx = position of the highest set bit of pending.
  - idx_last=1 iff pending has exactly one bit set.
- Handshake (idx_valid && idx_ready): clear bit idx in pending.
  - If idx_last: go to IDLE next cycle.
  - Otherwise the next idx is presented on the following cycle.
- Backpressure: while idx_valid && !idx_ready, idx and idx_last hold stable and pending is unchanged.
- Timing:
  - Capture at edge T gives first idx_valid in cycle T+1.
  - With idx_ready held high, k set bits drain in exactly k consecutive cycles.
  - req_ready returns high the cycle after the last beat.
  - No back-to-back capture during the final beat: minimum one IDLE cycle between vectors.
- All outputs are registered or decoded from registered state only; no combinational path from req or idx_ready to any output.
- The priority search is a combinational function of pending, valid for any N. It must not be a hard-coded case table.

Optional Feature:
- Macro: PSE_LSB_FIRST_EN
- Defined: priority is inverted. Bit 0 is highest; idx is the lowest set bit of pending; idx_last semantics unchanged.
- Not defined: MSB-first as described above.
- Only the search direction changes; the handshake and the state machine are identical in both builds.

Test Plan:
- N=8, req=8'b1010_0100 captured, idx_ready=1 → idx 7, 5, 2 on three consecutive cycles; idx_last=1 only with 2; req_ready=1 the following cycle.
- N=8, req=8'hFF, idx_ready=1 → idx 7..0 over eight back-to-back cycles, idx_last on 0. With PSE_LSB_FIRST_EN: 0..7, idx_last on 7.
- N=8, req=8'b0100_0001, idx_ready low 3 cycles after first valid → idx=6 held stable 3 cycles; then 6, 0 on accept; idx_last with 0.
- req=8'h00 captured → zero_err high one cycle; idx_valid never asserts; req_ready stays 1.
- req=8'b1110_0000, rst asserted after first beat (idx=7) accepted → next cycle idx_valid=0, req_ready=1; no beats for 6 or 5 follow.
- N=5, req=5'b10010 → idx=4 (3'b100), then idx=1 with idx_last; W=3 confirmed.
